// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared debounce state encoding and default sizing
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } db_state_t;

  localparam int DB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced push-button level, one-shot press pulse and press counter
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             BtnRaw,
  output logic             B,
  output logic             Level,
  output logic [CNT_W-1:0] PressCnt
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

  logic            sync;
  db_state_t       state, state_nxt;
  logic [DB_W-1:0] cnt, cnt_nxt;
  logic            b_nxt;

  sync_2ff u_sync (
    .clk   (Clk),
    .rst_n (Rst),
    .d     (BtnRaw),
    .q     (sync)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      B        <= 1'b0;
      PressCnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      B     <= b_nxt;
      if (b_nxt) PressCnt <= PressCnt + CNT_W'(1);
    end
  end

  // The count of stable samples includes the one that left the resting state,
  // so acceptance happens on the DB_CYCLES-th consecutive stable Sync.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    b_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_nxt = ARMING;
          cnt_nxt   = DB_ONE;
        end
      end
      ARMING: begin
        if (!sync) begin
          state_nxt = IDLE;
        end else if (cnt == DB_MAX) begin
          state_nxt = HELD;
          b_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + DB_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          state_nxt = RELEASING;
          cnt_nxt   = DB_ONE;
        end
      end
      RELEASING: begin
        if (sync) begin
          state_nxt = HELD;
        end else if (cnt == DB_MAX) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + DB_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Level = (state == HELD) || (state == RELEASING);

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, giving the consecutive stable cycles needed to accept a level change (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the press counter.
REQ-003 Port Clk  input  1  is the single clock; all state SHALL change only on its rising edge, except on reset.
REQ-004 Port Rst  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port BtnRaw  input  1  is the raw, asynchronous, bouncing push-button level.
REQ-006 Port B  output  1  is a one-cycle press pulse; it SHALL feed the B input of the downstream FSM.
REQ-007 Port Level  output  1  is the debounced button level.
REQ-008 Port PressCnt  output  CNT_W  is the number of accepted presses, modulo 2^CNT_W.

Function
REQ-009 BtnRaw SHALL pass through a 2-flop synchronizer; only its output (Sync) SHALL drive logic.
REQ-010 Debounce FSM states SHALL be IDLE (Level=0), ARMING (Level=0, counting), HELD (Level=1), and RELEASING (Level=1, counting).
REQ-011 IDLE->ARMING SHALL occur when Sync=1, and the debounce counter SHALL load 1.
REQ-012 In ARMING, Sync=1 SHALL increment the counter; Sync=0 SHALL return to IDLE with the counter cleared.
REQ-013 ARMING->HELD SHALL occur on the edge where the counter equals DB_CYCLES-1 and Sync=1; that edge SHALL set Level=1 and B=1.
REQ-014 HELD->RELEASING SHALL occur when Sync=0, and the counter SHALL load 1.
REQ-015 In RELEASING, Sync=0 SHALL increment the counter; Sync=1 SHALL return to HELD with the counter cleared.
REQ-016 RELEASING->IDLE SHALL occur when the counter equals DB_CYCLES-1 and Sync=0; that edge SHALL set Level=0, and B SHALL stay 0.
REQ-017 B SHALL be registered, high for exactly one cycle per accepted press, and never high in two consecutive cycles.
REQ-018 Latency: B SHALL be high in the cycle after the (2+DB_CYCLES)-th consecutive rising edge that samples BtnRaw=1.
REQ-019 Any BtnRaw pulse shorter than DB_CYCLES cycles (after synchronization) SHALL produce no B pulse and no Level change.
REQ-020 PressCnt SHALL increment on the same edge that asserts B, and SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-021 A press held indefinitely SHALL produce exactly one B pulse; a new pulse requires an accepted release first.

Reset
REQ-022 Asserting Rst=0 SHALL immediately force the state to IDLE and clear both synchronizer flops, the counter, B, Level and PressCnt.
REQ-023 Reset asserted mid-press (ARMING, HELD or RELEASING) SHALL discard the partial count and not emit B.
REQ-024 After release of Rst with BtnRaw held high, the full REQ-018 latency SHALL apply before B asserts.

Structure
REQ-025 A shared package SHALL hold the 2-bit state typedef (IDLE=0, ARMING=1, HELD=2, RELEASING=3) and the default DB_CYCLES/CNT_W constants.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async active-low reset to 0), reused elsewhere.
REQ-027 Counter width SHALL be the minimum that holds DB_CYCLES-1.

Verification
REQ-028 Reset, then BtnRaw=1 held 10 cycles (DB_CYCLES=4) -> B high exactly in cycle 7 after the first sampling edge; Level=1 from that cycle; PressCnt=1.
REQ-029 BtnRaw=1 for 3 cycles then 0 -> B never asserts; Level stays 0; PressCnt=0.
REQ-030 Press held 6+ cycles, bounce 0 for 2 cycles, back to 1 -> state returns to HELD; no second B pulse; PressCnt=1.
REQ-031 256 clean press/release pairs (CNT_W=8) -> PressCnt reads 0 after the 256th B pulse.
REQ-032 Rst pulsed low while in ARMING with count=2 -> all outputs 0 immediately; BtnRaw still 1 -> B after full 6-edge latency from reset release.
REQ-033 Chained with the downstream FSM on Clk/Rst, one clean press -> that FSM sees exactly one B pulse and produces its normal X response once.
